// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers debug bytes and issues them one at a time,
// pacing on the UART busy handshake, or on a timeout when busy never rises.
module uart_tx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  input  logic                  uart_busy,
  output logic                  uart_wr_o,
  output logic [DATA_WIDTH-1:0] uart_dat_o
);

  localparam int TMO_WIDTH = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
  localparam logic [TMO_WIDTH-1:0]  TMO_ONE    = TMO_WIDTH'(1);
  localparam logic [TMO_WIDTH-1:0]  TMO_LIMIT  = TMO_WIDTH'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t                 state, state_next;
  logic [TMO_WIDTH-1:0]   tmo, tmo_next;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr, rd_ptr;
  logic                   push, pop, load;

  assign full_o    = (count_o == FULL_COUNT);
  assign empty_o   = (count_o == '0);
  assign uart_wr_o = (state == ISSUE);

  assign pop  = (state == ISSUE);
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push = wr_i && (!full_o || pop);
  assign load = (state == IDLE) && (state_next == ISSUE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= dat_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_i && !push) begin
        overflow_o <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count_o <= count_o + COUNT_ONE;
        2'b01:   count_o <= count_o - COUNT_ONE;
        default: count_o <= count_o;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tmo        <= '0;
      uart_dat_o <= '0;
    end else begin
      state <= state_next;
      tmo   <= tmo_next;
      // Capture the head on entry to ISSUE so the data is valid alongside the strobe.
      if (load) begin
        uart_dat_o <= mem[rd_ptr];
      end
    end
  end

  always_comb begin
    state_next = state;
    tmo_next   = tmo;
    case (state)
      IDLE: begin
        if (!empty_o && !uart_busy) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT_HI;
        tmo_next   = '0;
      end
      WAIT_HI: begin
        if (uart_busy) begin
          state_next = WAIT_LO;
        end else begin
          tmo_next = tmo + TMO_ONE;
          if (tmo_next == TMO_LIMIT) begin
            state_next = IDLE;
          end
        end
      end
      WAIT_LO: begin
        if (!uart_busy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small UART busy model and a strobe monitor.
module tb_uart_tx_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_i;
  logic [DW-1:0] dat_i;
  logic          full_o;
  logic          empty_o;
  logic [AW:0]   count_o;
  logic          overflow_o;
  logic          uart_busy = 1'b0;
  logic          uart_wr_o;
  logic [DW-1:0] uart_dat_o;

  int vec_count = 0;
  int miss_count = 0;

  // Monitor / busy model state
  int busy_mode = 0;
  int pos_idx = 0;
  int strobes = 0;
  int b2b_err = 0;
  int gap_err = 0;
  int last_fall = -100;
  int dly = 0;
  int hold = 0;
  logic prev_wr = 1'b0;
  logic [DW-1:0] emitted [$];
  int strobe_at [$];

  uart_tx_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .BUSY_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .wr_i(wr_i), .dat_i(dat_i),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o), .overflow_o(overflow_o),
    .uart_busy(uart_busy), .uart_wr_o(uart_wr_o), .uart_dat_o(uart_dat_o)
  );

  always #5 clk = ~clk;

  // Mode 0: busy low, 1: busy high, 2: rise 2 cycles after strobe for 20, 3: random length
  always begin
    @(posedge clk);
    #1;
    pos_idx++;
    if (uart_wr_o) begin
      strobes++;
      emitted.push_back(uart_dat_o);
      strobe_at.push_back(pos_idx);
      if (prev_wr) b2b_err++;
      if (busy_mode >= 2 && (uart_busy || (pos_idx - last_fall) < 2)) gap_err++;
    end
    prev_wr = uart_wr_o;
    if (busy_mode == 0) begin
      uart_busy = 1'b0; dly = 0; hold = 0;
    end else if (busy_mode == 1) begin
      uart_busy = 1'b1; dly = 0; hold = 0;
    end else if (uart_wr_o) begin
      dly = 2;
    end else if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        uart_busy = 1'b1;
        hold = (busy_mode == 2) ? 20 : int'($urandom_range(1, 8));
      end
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) begin
        uart_busy = 1'b0;
        last_fall = pos_idx;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [DW-1:0] d);
    wr_i  = wr;
    dat_i = d;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, '0);
  endtask

  task automatic waitStrobes(input string tag, input int target, input int budget);
    int guard = 0;
    while (strobes < target && guard < budget) begin
      applyStimulus(1'b0, '0);
      guard++;
    end
    checkOutput(tag, strobes, target);
  endtask

  task automatic doReset();
    rst = 1'b0;
    idleCycles(2);
    rst = 1'b1;
    idleCycles(1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_wr"}, uart_wr_o, 0);
    checkOutput({tag, "_dat"}, uart_dat_o, 0);
    checkOutput({tag, "_count"}, count_o, 0);
    checkOutput({tag, "_empty"}, empty_o, 1);
    checkOutput({tag, "_full"}, full_o, 0);
    checkOutput({tag, "_ovf"}, overflow_o, 0);
  endtask

  initial begin
    int base;
    int pushes;
    int guard;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_q [$];

    rst = 1'b0; wr_i = 1'b0; dat_i = '0;
    @(negedge clk);
    checkResetValues("rst");
    rst = 1'b1;
    idleCycles(2);

    // Single byte latency and timeout pacing with busy tied low
    base = strobes;
    applyStimulus(1'b1, 8'hA5);
    checkOutput("sb_empty", empty_o, 0);
    checkOutput("sb_no_fallthru", uart_wr_o, 0);
    applyStimulus(1'b1, 8'h5A);
    checkOutput("sb_strobe", uart_wr_o, 1);
    checkOutput("sb_dat", uart_dat_o, 8'hA5);
    checkOutput("sb_count2", count_o, 2);
    applyStimulus(1'b0, '0);
    checkOutput("sb_strobe_end", uart_wr_o, 0);
    checkOutput("sb_dat_hold", uart_dat_o, 8'hA5);
    checkOutput("sb_count1", count_o, 1);
    waitStrobes("sb_wait", base + 2, 40);
    checkOutput("sb_spacing", strobe_at[base + 1] - strobe_at[base], TMO + 2);
    checkOutput("sb_second", emitted[base + 1], 8'h5A);
    idleCycles(10);

    // Asynchronous reset while in ISSUE
    applyStimulus(1'b1, 8'hC1);
    applyStimulus(1'b1, 8'hC2);
    checkOutput("mr_in_issue", uart_wr_o, 1);
    #2 rst = 1'b0;
    #1 checkResetValues("mr");
    @(negedge clk);
    rst = 1'b1;
    base = strobes;
    idleCycles(10);
    checkOutput("mr_count_after", count_o, 0);
    checkOutput("mr_no_strobe", strobes, base);

    // Busy handshake
    busy_mode = 2;
    idleCycles(2);
    base = strobes;
    applyStimulus(1'b1, 8'h11);
    applyStimulus(1'b1, 8'h22);
    applyStimulus(1'b1, 8'h33);
    waitStrobes("hs_wait", base + 3, 200);
    idleCycles(40);
    checkOutput("hs_total", strobes, base + 3);
    checkOutput("hs_b0", emitted[base], 8'h11);
    checkOutput("hs_b1", emitted[base + 1], 8'h22);
    checkOutput("hs_b2", emitted[base + 2], 8'h33);
    checkOutput("hs_gap", gap_err, 0);

    // Full and overflow with busy held high
    busy_mode = 1;
    idleCycles(3);
    base = strobes;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, DW'(i));
    checkOutput("ov_full", full_o, 1);
    checkOutput("ov_count16", count_o, 16);
    checkOutput("ov_not_yet", overflow_o, 0);
    applyStimulus(1'b1, 8'h10);
    checkOutput("ov_set", overflow_o, 1);
    checkOutput("ov_count_hold", count_o, 16);
    idleCycles(3);
    checkOutput("ov_sticky", overflow_o, 1);
    busy_mode = 0;
    waitStrobes("ov_wait", base + 16, 16 * (TMO + 2) + 40);
    idleCycles(20);
    checkOutput("ov_total", strobes, base + 16);
    for (int i = 0; i < 16; i++) checkOutput("ov_byte", emitted[base + i], i);
    checkOutput("ov_drained", count_o, 0);
    checkOutput("ov_sticky_end", overflow_o, 1);

    // Push while full on the ISSUE cycle
    doReset();
    busy_mode = 1;
    idleCycles(3);
    base = strobes;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, DW'(8'h80 + i));
    checkOutput("fp_full", full_o, 1);
    busy_mode = 0;
    guard = 0;
    while (!uart_wr_o && guard < 20) begin
      applyStimulus(1'b0, '0);
      guard++;
    end
    checkOutput("fp_issue", uart_wr_o, 1);
    applyStimulus(1'b1, 8'h77);
    checkOutput("fp_count", count_o, 16);
    checkOutput("fp_full_hold", full_o, 1);
    checkOutput("fp_no_ovf", overflow_o, 0);
    waitStrobes("fp_wait", base + 17, 17 * (TMO + 2) + 40);
    for (int i = 0; i < 16; i++) checkOutput("fp_byte", emitted[base + i], 8'h80 + i);
    checkOutput("fp_last", emitted[base + 16], 8'h77);

    // Pointer wrap with random gaps and random busy lengths
    busy_mode = 3;
    idleCycles(2);
    base = strobes;
    pushes = 0;
    guard = 0;
    while (pushes < 40 && guard < 3000) begin
      repeat ($urandom_range(0, 3)) begin
        applyStimulus(1'b0, '0);
        checkOutput("wr_count", count_o, pushes - (strobes - base - int'(uart_wr_o)));
        guard++;
      end
      if (!full_o) begin
        d = DW'($urandom);
        exp_q.push_back(d);
        applyStimulus(1'b1, d);
        pushes++;
      end else begin
        applyStimulus(1'b0, '0);
      end
      checkOutput("wr_count", count_o, pushes - (strobes - base - int'(uart_wr_o)));
      guard++;
    end
    waitStrobes("wr_wait", base + 40, 40 * 20 + 100);
    for (int i = 0; i < 40; i++) checkOutput("wr_byte", emitted[base + i], exp_q[i]);
    idleCycles(20);
    checkOutput("wr_empty", empty_o, 1);
    checkOutput("wr_gap", gap_err, 0);
    checkOutput("no_back2back", b2b_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and transmit sequencer between the DFT byte source (debug stream of PC/address/data/V0 bytes) and the UART transmitter. It accepts single-cycle byte write strobes at any rate up to one per clock, stores them in a FIFO, and issues them to the UART one at a time. It waits for the UART busy flag to rise and fall between bytes, so no byte is lost while the transmitter is shifting. If busy never rises, for example when busy is tied low, a timeout paces the stream.

## Interface

Parameters:
- DATA_WIDTH, 8: byte width on both sides.
- DEPTH, 16: FIFO entries; power of two, at least 2.
- ADDR_WIDTH, $clog2(DEPTH): pointer width.
- BUSY_TIMEOUT, 4: cycles to wait in WAIT_HI for uart_busy to rise before the byte is treated as accepted; at least 1.

Ports:
- clk, input, 1: system clock. One clock domain.
- rst, input, 1: asynchronous, active-low reset.
- wr_i, input, 1: push strobe from the byte source; one byte per high cycle.
- dat_i, input, DATA_WIDTH: byte to push; sampled when wr_i is high.
- full_o, output, 1: count_o == DEPTH.
- empty_o, output, 1: count_o == 0.
- count_o, output, ADDR_WIDTH+1: current occupancy.
- overflow_o, output, 1: sticky; set when a push is dropped; cleared only by reset.
- uart_busy, input, 1: UART transmitting flag.
- uart_wr_o, output, 1: single-cycle transmit strobe to the UART.
- uart_dat_o, output, DATA_WIDTH: byte to the UART. Registered and held stable from ISSUE until the next ISSUE.

## Operation

- Storage:
  - Circular buffer with ADDR_WIDTH-bit read and write pointers that wrap modulo DEPTH.
  - count_o is a separate register, not derived from the pointers.
- Push:
  - Accepted on a rising edge where wr_i=1 and either count_o<DEPTH, or a pop occurs in the same cycle.
  - Otherwise the byte is dropped, the pointers and count are unchanged, and overflow_o is set.
- Pop: occurs only in state ISSUE. The head byte goes to uart_dat_o and the read pointer advances.
- Simultaneous push and pop: count_o is unchanged, both pointers advance, and this holds when full.
- Push into an empty FIFO: the byte is not visible to the FSM until the next cycle. There is no fall-through.
- FSM states:
  - IDLE: go to ISSUE when empty_o=0 and uart_busy=0; otherwise stay.
  - ISSUE (1 cycle): uart_wr_o=1, uart_dat_o←head, pop; go to WAIT_HI and clear the timeout counter.
  - WAIT_HI:
    - If uart_busy=1, go to WAIT_LO.
    - Otherwise increment the counter; when it reaches BUSY_TIMEOUT, go to IDLE.
  - WAIT_LO: when uart_busy=0, go to IDLE.
- Illegal state encodings return to IDLE.
- Timeout counter width: $clog2(BUSY_TIMEOUT+1).

## Timing

- Reset (rst=0, asynchronous, takes effect immediately without a clock):
  - uart_wr_o=0, uart_dat_o=0, count_o=0, empty_o=1, full_o=0, overflow_o=0.
  - Pointers 0, state IDLE, counter 0.
  - Buffered bytes are discarded.
  - Reset during ISSUE drops uart_wr_o immediately. The byte is lost, and this is intended.
- All outputs are registered or decoded from registers; there are no combinational paths from inputs to outputs.
- Latency, for an empty FIFO in IDLE with uart_busy=0:
  - wr_i sampled at edge k.
  - empty_o=0 after edge k.
  - ISSUE entered at edge k+1, so uart_wr_o is high between edges k+1 and k+2.
  - Pop at edge k+2.
- Throughput with busy tied low: one byte per BUSY_TIMEOUT+2 cycles (ISSUE + BUSY_TIMEOUT in WAIT_HI + IDLE).
- Throughput with a real UART: one byte per UART frame time plus 2 cycles.
- uart_wr_o is never high on two consecutive cycles.

## Test plan

- Reset values: assert rst=0 mid-stream while in ISSUE. uart_wr_o falls within the same cycle, all outputs reach their reset values, and after release count_o=0 with no strobe.
- Single byte, busy tied 0: push 0xA5 at edge k. uart_wr_o is high exactly in cycle k+1..k+2 with uart_dat_o=0xA5, and the next ISSUE cannot occur before edge k+2+BUSY_TIMEOUT+1.
- Busy handshake: push 0x11, 0x22, 0x33 back-to-back; model busy rising 2 cycles after each strobe and staying high for 20 cycles. Exactly three strobes appear in order 0x11, 0x22, 0x33, and each strobe comes at least one cycle after busy fell.
- Full and overflow:
  - With busy held high, push 17 bytes (0x00..0x10).
  - full_o=1 after the 16th push; the 17th is dropped and overflow_o=1 and stays set.
  - After busy is released, exactly 0x00..0x0F are emitted.
- Push while full with a pop in the same cycle:
  - Fill 16 bytes, then push 0x77 on the ISSUE cycle.
  - The push is accepted, count_o stays 16 and overflow_o stays 0.
  - 0x77 is emitted last after the pointers wrap.
- Pointer wrap: stream 40 bytes with random wr_i gaps and random busy lengths. The output sequence equals the input sequence, and count_o always equals pushes minus pops.
